// File: rtl/oam_dma_engine.sv
// OAM DMA engine: register FF46 selects a source page and XFER_LEN bytes are copied
// from {page,00} into OAM at FE00, one byte every CYCLES_PER_BYTE clocks.
module oam_dma_engine #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int STARTUP_CYCLES  = 4,
    parameter int XFER_LEN        = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic        reg_read_en,
    input  logic        reg_write_en,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] src_addr,
    output logic        src_read_en,
    input  logic [7:0]  src_rdata,
    output logic [15:0] oam_addr,
    output logic        oam_write_en,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic [1:0]  dbg_state
);

    localparam int SUB_MAX = (CYCLES_PER_BYTE > STARTUP_CYCLES) ? CYCLES_PER_BYTE : STARTUP_CYCLES;
    localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         src_page_q, src_page_d;
    logic [7:0]         byte_idx_q, byte_idx_d;
    logic [SUB_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic [15:0]        src_addr_q, src_addr_d;
    logic               ff46_wr;
    logic               strobe_cycle;

    // Pages E0-FF alias the C0-DF work RAM echo.
    function automatic logic [7:0] eff_page(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

    assign ff46_wr      = reg_write_en && (reg_addr == 16'hFF46);
    assign strobe_cycle = (state_q == ST_XFER) && (sub_cnt_q == SUB_W'(CYCLES_PER_BYTE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            src_page_q <= 8'hFF;
            byte_idx_q <= 8'h00;
            sub_cnt_q  <= '0;
            src_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            src_page_q <= src_page_d;
            byte_idx_q <= byte_idx_d;
            sub_cnt_q  <= sub_cnt_d;
            src_addr_q <= src_addr_d;
        end
    end

    // A register write wins over the sequencing below, but the strobe of the
    // current byte is driven from the present state so it still lands this cycle.
    always_comb begin
        state_d    = state_q;
        src_page_d = src_page_q;
        byte_idx_d = byte_idx_q;
        sub_cnt_d  = sub_cnt_q;
        if (ff46_wr) begin
            state_d    = ST_START;
            src_page_d = reg_wdata;
            byte_idx_d = 8'h00;
            sub_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (sub_cnt_q == SUB_W'(STARTUP_CYCLES - 1)) begin
                        state_d   = ST_XFER;
                        sub_cnt_d = '0;
                    end else begin
                        sub_cnt_d = sub_cnt_q + SUB_W'(1);
                    end
                end
                ST_XFER: begin
                    if (strobe_cycle) begin
                        sub_cnt_d = '0;
                        if (byte_idx_q == 8'(XFER_LEN - 1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + 8'd1;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + SUB_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        src_addr_d = (state_d != ST_IDLE) ? {eff_page(src_page_d), byte_idx_d} : src_addr_q;
    end

    always_comb begin
        dma_active   = (state_q != ST_IDLE);
        src_read_en  = strobe_cycle;
        oam_write_en = strobe_cycle;
        src_addr     = src_addr_q;
        oam_addr     = {8'hFE, byte_idx_q};
        oam_wdata    = src_rdata;
        reg_rdata    = (reg_read_en && (reg_addr == 16'hFF46)) ? src_page_q : 8'hFF;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: a source-memory model feeds the engine and every
// expected OAM write (cycle, source address, OAM address, data) is queued and matched.
module tb_oam_dma_engine;

    localparam int STARTUP = 4;
    localparam int CPB     = 4;
    localparam int LEN     = 160;
    localparam int ACTIVE  = STARTUP + CPB * LEN;

    logic        clk;
    logic        reset;
    logic [15:0] reg_addr;
    logic        reg_read_en;
    logic        reg_write_en;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [15:0] src_addr;
    logic        src_read_en;
    logic [7:0]  src_rdata;
    logic [15:0] oam_addr;
    logic        oam_write_en;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic [1:0]  dbg_state;

    logic [7:0]  mem [0:65535];
    logic [63:0] exp_q[$];
    int unsigned cyc = 0;
    int unsigned act_start = 1;
    int unsigned act_end = 0;
    int          vectors = 0;
    int          miscompares = 0;

    oam_dma_engine dut (
        .clk(clk), .reset(reset),
        .reg_addr(reg_addr), .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .src_addr(src_addr), .src_read_en(src_read_en), .src_rdata(src_rdata),
        .oam_addr(oam_addr), .oam_write_en(oam_write_en), .oam_wdata(oam_wdata),
        .dma_active(dma_active), .dbg_state(dbg_state)
    );

    assign src_rdata = mem[src_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: one sample per cycle, well after the active edge.
    always @(posedge clk) begin
        logic        exp_strobe;
        logic        exp_act;
        logic [63:0] ent;
        #1;
        exp_strobe = (exp_q.size() > 0) && (exp_q[0][63:40] == cyc[23:0]);
        exp_act    = (cyc >= act_start) && (cyc <= act_end);
        check("oam_write_en", {63'd0, oam_write_en}, {63'd0, exp_strobe});
        check("src_read_en", {63'd0, src_read_en}, {63'd0, exp_strobe});
        check("dma_active", {63'd0, dma_active}, {63'd0, exp_act});
        if (exp_strobe) begin
            ent = exp_q.pop_front();
            check("byte_xfer", {cyc[23:0], src_addr, oam_addr, oam_wdata}, ent);
        end else if ((exp_q.size() > 0) && (exp_q[0][63:40] < cyc[23:0])) begin
            ent = exp_q.pop_front();
            check("missed_byte", {cyc[23:0], src_addr, oam_addr, oam_wdata}, ent);
        end
    end

    // Drive an FF46 write sampled at the coming edge; queue the whole copy it implies.
    task automatic do_write(input logic [7:0] page, output int unsigned base);
        logic [7:0] eff;
        logic [15:0] sa;
        base = cyc;
        reg_addr = 16'hFF46;
        reg_wdata = page;
        reg_write_en = 1'b1;
        while ((exp_q.size() > 0) && (exp_q[$][63:40] > base[23:0])) void'(exp_q.pop_back());
        if (!((base >= act_start) && (base <= act_end))) act_start = base + 1;
        act_end = base + ACTIVE;
        eff = (page >= 8'hE0) ? page - 8'h20 : page;
        for (int i = 0; i < LEN; i++) begin
            int unsigned t;
            t = base + STARTUP + CPB * (i + 1);
            sa = {eff, 8'(i)};
            exp_q.push_back({t[23:0], sa, {8'hFE, 8'(i)}, mem[sa]});
        end
        @(negedge clk);
        reg_write_en = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [15:0] addr, input logic [7:0] expv);
        reg_addr = addr;
        reg_read_en = 1'b1;
        #1;
        check(tag, {56'd0, reg_rdata}, {56'd0, expv});
        reg_read_en = 1'b0;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (((cyc <= act_end + 1) || (exp_q.size() > 0)) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, (n >= 2000)}, 64'd0);
    endtask

    initial begin
        int unsigned b1;
        int unsigned b2;
        logic [7:0] pg;
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = 16'(a);
            mem[a] = av[7:0] ^ av[15:8] ^ 8'h9A;
        end
        reset = 1'b0;
        reg_addr = 16'h0000;
        reg_read_en = 1'b0;
        reg_write_en = 1'b0;
        reg_wdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_dma_active", {63'd0, dma_active}, 64'd0);
        check("rst_src_addr", {48'd0, src_addr}, 64'h0000);
        check("rst_oam_addr", {48'd0, oam_addr}, 64'hFE00);
        reg_read("rst_ff46", 16'hFF46, 8'hFF);

        // Straight copy from C000 (bytes are i^5A there).
        do_write(8'hC0, b1);
        wait_done("copy_c0_done");

        // Echo page: E1 reads from C100.
        do_write(8'hE1, b1);
        reg_read("read_ff46", 16'hFF46, 8'hE1);
        reg_read("read_ff47", 16'hFF47, 8'hFF);
        reg_addr = 16'hFF46;
        #1;
        check("ff46_no_strobe", {56'd0, reg_rdata}, 64'hFF);
        wait_done("copy_e1_done");

        // Reset in the middle of byte 50 aborts the copy.
        pg = 8'($urandom_range(0, 255));
        do_write(pg, b1);
        wait_until(b1 + STARTUP + CPB * 50 + 2);
        reset = 1'b0;
        exp_q.delete();
        act_start = 1;
        act_end = 0;
        #1;
        check("abort_dma_active", {63'd0, dma_active}, 64'd0);
        check("abort_src_addr", {48'd0, src_addr}, 64'h0000);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        reg_read("abort_ff46", 16'hFF46, 8'hFF);
        repeat (50) @(negedge clk);

        // Restart on the strobe cycle of byte 23.
        do_write(8'hC0, b1);
        wait_until(b1 + 100);
        do_write(8'hD0, b2);
        wait_done("restart_done");
        check("restart_end", {32'd0, act_end}, {32'd0, b2 + ACTIVE});

        // Restart on the strobe cycle of the final byte.
        pg = 8'($urandom_range(0, 255));
        do_write(pg, b1);
        wait_until(b1 + ACTIVE);
        pg = 8'($urandom_range(0, 255));
        do_write(pg, b2);
        check("last_restart_active", {63'd0, dma_active}, 64'd1);
        wait_done("last_restart_done");

        // Long idle stretch: the per-cycle checks expect no activity.
        repeat (1000) @(negedge clk);
        check("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
